arf_rat: RTL and testbench
==========================

Name: arf_rat

Overview:
- Architectural register file plus register alias table (RAT); sits at the retire end of the ROB.
- Accepts the ROB's retire stream: commits retired destination data into architectural state and clears the matching rename tag.
- Accepts the dispatch rename of each destination (arf_id -> rob_id).
- Answers two source-operand lookups per cycle: ARF data if the register is not renamed, otherwise the producing rob_id for the ROB lookup.

Parameters:
- N_ARF, 32, number of architectural registers; register 0 is hardwired zero.
- ARF_ID_WIDTH, 5, log2(N_ARF).
- REG_DATA_WIDTH, 32, register data width.
- ROB_ID_WIDTH, 4, width of ROB tags (ROB_N_ENTRIES = 16).

Ports:
- clk  input  1  clock
- rst_aL  input  1  asynchronous active-low reset
- dispatch_fire  input  1  dispatch handshake completed this cycle (valid & all readies)
- dispatch_dst_valid  input  1  dispatched instruction writes a destination
- dispatch_dst_arf_id  input  ARF_ID_WIDTH  destination architectural register
- dispatch_rob_id  input  ROB_ID_WIDTH  ROB tag allocated to the dispatched instruction
- retire  input  1  ROB head retiring with destination write
- retire_rob_id  input  ROB_ID_WIDTH  tag of retiring entry
- retire_arf_id  input  ARF_ID_WIDTH  destination of retiring entry
- retire_reg_data  input  REG_DATA_WIDTH  result of retiring entry
- flush  input  1  pipeline flush (mispredict recovery); ROB emptied same cycle
- src1_arf_id  input  ARF_ID_WIDTH  source 1 lookup address
- src1_renamed  output  1  1 = value pending in ROB, use src1_rob_id
- src1_rob_id  output  ROB_ID_WIDTH  producing tag (valid when src1_renamed)
- src1_reg_data  output  REG_DATA_WIDTH  ARF value (valid when !src1_renamed)
- src2_arf_id / src2_renamed / src2_rob_id / src2_reg_data  same as src1 for source 2
- n_renamed  output  ARF_ID_WIDTH+1  count of registers currently renamed

Behaviour:
- State per register i: data[i], renamed[i], tag[i].
- Reset (async, rst_aL=0): all data=0, renamed=0, tag=0, n_renamed=0. Reset mid-operation discards all renames immediately; outputs reflect reset state combinationally.
- Register 0: never renamed; dispatch and retire writes to x0 are ignored; srcN reads of x0 always return renamed=0, data=0.
- Lookup (combinational, 0 cycles): reflects state at the start of the cycle, with a retire bypass. If retire && retire_arf_id==srcN_arf_id && renamed && tag==retire_rob_id, then srcN_renamed=0 and srcN_reg_data=retire_reg_data. Same-cycle dispatch rename is NOT visible; the dispatch stage handles intra-bundle dependences.
- Retire (clock edge, retire=1, arf_id!=0): data[arf_id] <= retire_reg_data unconditionally. renamed[arf_id] <= 0 only if tag[arf_id]==retire_rob_id (no younger rename outstanding).
- Dispatch rename (clock edge, dispatch_fire && dispatch_dst_valid && arf_id!=0): renamed <= 1, tag <= dispatch_rob_id.
- Simultaneous retire and dispatch to the same register: data updated by retire; renamed stays 1 and tag takes dispatch_rob_id (dispatch wins).
- Flush (clock edge): all renamed <= 0. A retire in the same cycle still commits its data. A dispatch in the same cycle is ignored (flush wins).
- n_renamed: registered popcount of renamed[]; updated in the same edge as the state, so it equals the popcount of the post-edge state. Increments only on a not-renamed -> renamed transition; re-renaming an already renamed register leaves it unchanged.
- ROB tag wrap-around: tags are compared by equality only. The ROB guarantees no tag is reallocated while its entry is live, so stale-tag aliasing cannot occur.

Test Plan:
- Reset then read src1=5, src2=0 -> renamed=0, data=0, n_renamed=0.
- Dispatch x5 -> rob 3. Next cycle src1=5 -> renamed=1, rob_id=3; n_renamed=1.
- Retire rob 3, x5, 0xDEADBEEF. Same cycle src1=5 -> renamed=0, data=0xDEADBEEF (bypass). Next cycle -> same values from state; n_renamed=0.
- Dispatch x7 -> rob 1, then x7 -> rob 2. Retire rob 1 (0x11) -> x7 stays renamed with tag 2, data=0x11. Retire rob 2 (0x22) -> renamed=0, data=0x22.
- Same cycle: retire rob 4 to x9 with 0xAA and dispatch x9 -> rob 6. Next cycle -> renamed=1, tag=6, data=0xAA.
- Rename x1..x3. Assert flush with a simultaneous retire of x2 (0x55) and dispatch of x4 -> all renamed=0, x2 data=0x55, x4 not renamed, n_renamed=0. Dispatch or retire to x0 -> x0 reads 0, never renamed.

Source files
------------

// File: rtl/arf_rat_if.sv
// Dispatch/retire/lookup bundle between the rename stage, ROB retire port and the ARF+RAT.
// The master drives updates and lookup addresses; the slave returns lookup results and the rename count.
interface arf_rat_if #(
  parameter int ARF_ID_WIDTH   = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int ROB_ID_WIDTH   = 4
);
  logic                      dispatch_fire;
  logic                      dispatch_dst_valid;
  logic [ARF_ID_WIDTH-1:0]   dispatch_dst_arf_id;
  logic [ROB_ID_WIDTH-1:0]   dispatch_rob_id;

  logic                      retire;
  logic [ROB_ID_WIDTH-1:0]   retire_rob_id;
  logic [ARF_ID_WIDTH-1:0]   retire_arf_id;
  logic [REG_DATA_WIDTH-1:0] retire_reg_data;

  logic                      flush;

  logic [ARF_ID_WIDTH-1:0]   src1_arf_id;
  logic                      src1_renamed;
  logic [ROB_ID_WIDTH-1:0]   src1_rob_id;
  logic [REG_DATA_WIDTH-1:0] src1_reg_data;

  logic [ARF_ID_WIDTH-1:0]   src2_arf_id;
  logic                      src2_renamed;
  logic [ROB_ID_WIDTH-1:0]   src2_rob_id;
  logic [REG_DATA_WIDTH-1:0] src2_reg_data;

  logic [ARF_ID_WIDTH:0]     n_renamed;

  modport master (
    output dispatch_fire, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_rob_id,
    output retire, retire_rob_id, retire_arf_id, retire_reg_data,
    output flush,
    output src1_arf_id, src2_arf_id,
    input  src1_renamed, src1_rob_id, src1_reg_data,
    input  src2_renamed, src2_rob_id, src2_reg_data,
    input  n_renamed
  );

  modport slave (
    input  dispatch_fire, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_rob_id,
    input  retire, retire_rob_id, retire_arf_id, retire_reg_data,
    input  flush,
    input  src1_arf_id, src2_arf_id,
    output src1_renamed, src1_rob_id, src1_reg_data,
    output src2_renamed, src2_rob_id, src2_reg_data,
    output n_renamed
  );
endinterface

// File: rtl/arf_rat.sv
// Architectural register file + rename alias table: two 0-cycle lookups with retire bypass, updates on the edge.
// No backpressure: every retire/dispatch/flush presented is absorbed in the cycle it arrives.
module arf_rat #(
  parameter int N_ARF          = 32,
  parameter int ARF_ID_WIDTH   = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int ROB_ID_WIDTH   = 4
) (
  input  logic      clk,
  input  logic      rst_aL,
  arf_rat_if.slave  bus
);

  logic [REG_DATA_WIDTH-1:0] data_q [N_ARF];
  logic [REG_DATA_WIDTH-1:0] data_d [N_ARF];
  logic [ROB_ID_WIDTH-1:0]   tag_q  [N_ARF];
  logic [ROB_ID_WIDTH-1:0]   tag_d  [N_ARF];
  logic [N_ARF-1:0]          renamed_q;
  logic [N_ARF-1:0]          renamed_d;
  logic [ARF_ID_WIDTH:0]     n_renamed_q;
  logic [ARF_ID_WIDTH:0]     n_renamed_d;

  logic retire_ok;
  logic dispatch_ok;

  assign retire_ok   = bus.retire && (bus.retire_arf_id != '0);
  assign dispatch_ok = bus.dispatch_fire && bus.dispatch_dst_valid &&
                       (bus.dispatch_dst_arf_id != '0) && !bus.flush;

  always_comb begin
    data_d      = data_q;
    tag_d       = tag_q;
    renamed_d   = renamed_q;
    n_renamed_d = '0;

    if (retire_ok) begin
      data_d[bus.retire_arf_id] = bus.retire_reg_data;
      // A younger rename of the same register keeps it pending.
      if (tag_q[bus.retire_arf_id] == bus.retire_rob_id) begin
        renamed_d[bus.retire_arf_id] = 1'b0;
      end
    end

    if (bus.flush) begin
      renamed_d = '0;
    end else if (dispatch_ok) begin
      renamed_d[bus.dispatch_dst_arf_id] = 1'b1;
      tag_d[bus.dispatch_dst_arf_id]     = bus.dispatch_rob_id;
    end

    for (int i = 0; i < N_ARF; i++) begin
      n_renamed_d = n_renamed_d + (ARF_ID_WIDTH+1)'(renamed_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      for (int i = 0; i < N_ARF; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      renamed_q   <= '0;
      n_renamed_q <= '0;
    end else begin
      data_q      <= data_d;
      tag_q       <= tag_d;
      renamed_q   <= renamed_d;
      n_renamed_q <= n_renamed_d;
    end
  end

  logic bypass1;
  logic bypass2;
  logic zero1;
  logic zero2;

  // Retire of the exact producer forwards its result; a stale tag does not.
  assign bypass1 = bus.retire && (bus.retire_arf_id == bus.src1_arf_id) &&
                   renamed_q[bus.src1_arf_id] && (tag_q[bus.src1_arf_id] == bus.retire_rob_id);
  assign bypass2 = bus.retire && (bus.retire_arf_id == bus.src2_arf_id) &&
                   renamed_q[bus.src2_arf_id] && (tag_q[bus.src2_arf_id] == bus.retire_rob_id);
  assign zero1   = (bus.src1_arf_id == '0);
  assign zero2   = (bus.src2_arf_id == '0);

  always_comb begin
    bus.src1_renamed  = renamed_q[bus.src1_arf_id] && !bypass1 && !zero1;
    bus.src1_rob_id   = tag_q[bus.src1_arf_id];
    bus.src1_reg_data = zero1   ? '0 :
                        bypass1 ? bus.retire_reg_data : data_q[bus.src1_arf_id];

    bus.src2_renamed  = renamed_q[bus.src2_arf_id] && !bypass2 && !zero2;
    bus.src2_rob_id   = tag_q[bus.src2_arf_id];
    bus.src2_reg_data = zero2   ? '0 :
                        bypass2 ? bus.retire_reg_data : data_q[bus.src2_arf_id];

    bus.n_renamed     = n_renamed_q;
  end

endmodule

// File: tb/tb_arf_rat.sv
// Directed bench for arf_rat: rename, retire bypass, same-register ordering, flush and x0 handling.
module tb_arf_rat;
  logic clk;
  logic rst_aL;
  int   total;
  int   bad;

  arf_rat_if #(.ARF_ID_WIDTH(5), .REG_DATA_WIDTH(32), .ROB_ID_WIDTH(4)) bus ();

  arf_rat #(.N_ARF(32), .ARF_ID_WIDTH(5), .REG_DATA_WIDTH(32), .ROB_ID_WIDTH(4)) dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.dispatch_fire       = 1'b0;
    bus.dispatch_dst_valid  = 1'b0;
    bus.dispatch_dst_arf_id = '0;
    bus.dispatch_rob_id     = '0;
    bus.retire              = 1'b0;
    bus.retire_rob_id       = '0;
    bus.retire_arf_id       = '0;
    bus.retire_reg_data     = '0;
    bus.flush               = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic dispatch(input logic [4:0] a, input logic [3:0] r);
    bus.dispatch_fire       = 1'b1;
    bus.dispatch_dst_valid  = 1'b1;
    bus.dispatch_dst_arf_id = a;
    bus.dispatch_rob_id     = r;
  endtask

  task automatic retire(input logic [4:0] a, input logic [3:0] r, input logic [31:0] d);
    bus.retire          = 1'b1;
    bus.retire_arf_id   = a;
    bus.retire_rob_id   = r;
    bus.retire_reg_data = d;
  endtask

  task automatic test_reset();
    rst_aL = 1'b0;
    idle();
    bus.src1_arf_id = 5'd5;
    bus.src2_arf_id = 5'd0;
    #12;
    total++; if (bus.src1_renamed !== 1'b0) begin bad++; $display("FAIL reset_src1_renamed got=%0d exp=0", bus.src1_renamed); end
    total++; if (bus.src1_reg_data !== 32'h0) begin bad++; $display("FAIL reset_src1_data got=%h exp=0", bus.src1_reg_data); end
    total++; if (bus.src2_renamed !== 1'b0 || bus.src2_reg_data !== 32'h0) begin bad++; $display("FAIL reset_src2 got=%0d/%h exp=0/0", bus.src2_renamed, bus.src2_reg_data); end
    total++; if (bus.n_renamed !== 6'd0) begin bad++; $display("FAIL reset_n_renamed got=%0d exp=0", bus.n_renamed); end
    @(negedge clk);
    rst_aL = 1'b1;
    step();
  endtask

  task automatic test_rename();
    dispatch(5'd5, 4'd3);
    bus.src1_arf_id = 5'd5;
    #1;
    total++; if (bus.src1_renamed !== 1'b0) begin bad++; $display("FAIL rename_not_same_cycle got=%0d exp=0", bus.src1_renamed); end
    step();
    total++; if (bus.src1_renamed !== 1'b1 || bus.src1_rob_id !== 4'd3) begin bad++; $display("FAIL rename_x5 got=%0d/%0d exp=1/3", bus.src1_renamed, bus.src1_rob_id); end
    total++; if (bus.n_renamed !== 6'd1) begin bad++; $display("FAIL rename_count got=%0d exp=1", bus.n_renamed); end
  endtask

  task automatic test_retire_bypass();
    retire(5'd5, 4'd3, 32'hDEADBEEF);
    bus.src1_arf_id = 5'd5;
    bus.src2_arf_id = 5'd5;
    #1;
    total++; if (bus.src1_renamed !== 1'b0 || bus.src1_reg_data !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_src1 got=%0d/%h exp=0/deadbeef", bus.src1_renamed, bus.src1_reg_data); end
    total++; if (bus.src2_renamed !== 1'b0 || bus.src2_reg_data !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_src2 got=%0d/%h exp=0/deadbeef", bus.src2_renamed, bus.src2_reg_data); end
    step();
    total++; if (bus.src1_renamed !== 1'b0 || bus.src1_reg_data !== 32'hDEADBEEF) begin bad++; $display("FAIL retire_state got=%0d/%h exp=0/deadbeef", bus.src1_renamed, bus.src1_reg_data); end
    total++; if (bus.n_renamed !== 6'd0) begin bad++; $display("FAIL retire_count got=%0d exp=0", bus.n_renamed); end
  endtask

  task automatic test_back_to_back();
    bus.src1_arf_id = 5'd7;
    dispatch(5'd7, 4'd1);
    step();
    dispatch(5'd7, 4'd2);
    step();
    total++; if (bus.src1_rob_id !== 4'd2 || bus.n_renamed !== 6'd1) begin bad++; $display("FAIL rerename got=%0d/%0d exp=2/1", bus.src1_rob_id, bus.n_renamed); end
    retire(5'd7, 4'd1, 32'h11);
    #1;
    total++; if (bus.src1_renamed !== 1'b1) begin bad++; $display("FAIL stale_no_bypass got=%0d exp=1", bus.src1_renamed); end
    step();
    total++; if (bus.src1_renamed !== 1'b1 || bus.src1_rob_id !== 4'd2 || bus.src1_reg_data !== 32'h11) begin bad++; $display("FAIL stale_retire got=%0d/%0d/%h exp=1/2/11", bus.src1_renamed, bus.src1_rob_id, bus.src1_reg_data); end
    retire(5'd7, 4'd2, 32'h22);
    step();
    total++; if (bus.src1_renamed !== 1'b0 || bus.src1_reg_data !== 32'h22 || bus.n_renamed !== 6'd0) begin bad++; $display("FAIL final_retire got=%0d/%h/%0d exp=0/22/0", bus.src1_renamed, bus.src1_reg_data, bus.n_renamed); end
  endtask

  task automatic test_same_cycle();
    bus.src1_arf_id = 5'd9;
    retire(5'd9, 4'd4, 32'hAA);
    dispatch(5'd9, 4'd6);
    step();
    total++; if (bus.src1_renamed !== 1'b1 || bus.src1_rob_id !== 4'd6 || bus.src1_reg_data !== 32'hAA) begin bad++; $display("FAIL same_cycle got=%0d/%0d/%h exp=1/6/aa", bus.src1_renamed, bus.src1_rob_id, bus.src1_reg_data); end
    total++; if (bus.n_renamed !== 6'd1) begin bad++; $display("FAIL same_cycle_count got=%0d exp=1", bus.n_renamed); end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      dispatch(5'(i), 4'(7 + i));
      step();
    end
    total++; if (bus.n_renamed !== 6'd4) begin bad++; $display("FAIL pre_flush_count got=%0d exp=4", bus.n_renamed); end
    bus.flush = 1'b1;
    retire(5'd2, 4'd9, 32'h55);
    dispatch(5'd4, 4'd11);
    step();
    bus.src1_arf_id = 5'd2;
    bus.src2_arf_id = 5'd4;
    #1;
    total++; if (bus.src1_renamed !== 1'b0 || bus.src1_reg_data !== 32'h55) begin bad++; $display("FAIL flush_x2 got=%0d/%h exp=0/55", bus.src1_renamed, bus.src1_reg_data); end
    total++; if (bus.src2_renamed !== 1'b0) begin bad++; $display("FAIL flush_x4 got=%0d exp=0", bus.src2_renamed); end
    bus.src1_arf_id = 5'd1;
    bus.src2_arf_id = 5'd9;
    #1;
    total++; if (bus.src1_renamed !== 1'b0 || bus.src2_renamed !== 1'b0) begin bad++; $display("FAIL flush_others got=%0d/%0d exp=0/0", bus.src1_renamed, bus.src2_renamed); end
    total++; if (bus.n_renamed !== 6'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", bus.n_renamed); end
  endtask

  task automatic test_x0();
    bus.src1_arf_id = 5'd0;
    dispatch(5'd0, 4'd5);
    retire(5'd0, 4'd0, 32'h99);
    #1;
    total++; if (bus.src1_renamed !== 1'b0 || bus.src1_reg_data !== 32'h0) begin bad++; $display("FAIL x0_bypass got=%0d/%h exp=0/0", bus.src1_renamed, bus.src1_reg_data); end
    step();
    total++; if (bus.src1_renamed !== 1'b0 || bus.src1_reg_data !== 32'h0 || bus.n_renamed !== 6'd0) begin bad++; $display("FAIL x0_state got=%0d/%h/%0d exp=0/0/0", bus.src1_renamed, bus.src1_reg_data, bus.n_renamed); end
  endtask

  task automatic test_reset_mid();
    dispatch(5'd6, 4'd12);
    step();
    dispatch(5'd31, 4'd13);
    step();
    bus.src1_arf_id = 5'd31;
    #1;
    total++; if (bus.src1_renamed !== 1'b1 || bus.src1_rob_id !== 4'd13 || bus.n_renamed !== 6'd2) begin bad++; $display("FAIL top_reg got=%0d/%0d/%0d exp=1/13/2", bus.src1_renamed, bus.src1_rob_id, bus.n_renamed); end
    bus.src1_arf_id = 5'd6;
    bus.src2_arf_id = 5'd5;
    #2;
    rst_aL = 1'b0;
    #1;
    total++; if (bus.src1_renamed !== 1'b0 || bus.n_renamed !== 6'd0) begin bad++; $display("FAIL mid_reset_rename got=%0d/%0d exp=0/0", bus.src1_renamed, bus.n_renamed); end
    total++; if (bus.src2_reg_data !== 32'h0) begin bad++; $display("FAIL mid_reset_data got=%h exp=0", bus.src2_reg_data); end
    @(negedge clk);
    rst_aL = 1'b1;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.src1_arf_id = '0;
    bus.src2_arf_id = '0;
    test_reset();
    test_rename();
    test_retire_bypass();
    test_back_to_back();
    test_same_cycle();
    test_flush();
    test_x0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
